// File: rtl/pea_invoke_ctrl.sv
// pea_invoke_ctrl: pops one command, decodes it, waits for FIFO room/data, invokes the PEA core and watches for completion
module pea_invoke_ctrl #(
    parameter int WORD_SIZE      = 16,
    parameter int BUFFER_SIZE    = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(BUFFER_SIZE)-1:0] command_pop,
    input  logic [$clog2(BUFFER_SIZE)-1:0] data_pop,
    input  logic [$clog2(BUFFER_SIZE)-1:0] result_free_space,
    input  logic [$clog2(BUFFER_SIZE)-1:0] status_free_space,
    input  logic [WORD_SIZE-1:0]           cmd_data,
    input  logic                           core_done,
    output logic                           cmd_rd_en,
    output logic                           core_start,
    output logic [7:0]                     core_mode,
    output logic [2:0]                     core_arg1,
    output logic [4:0]                     core_arg2,
    output logic                           busy,
    output logic                           err,
    output logic [1:0]                     err_code,
    output logic [15:0]                    invoke_count
);
    localparam int AW = $clog2(BUFFER_SIZE);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, CHECK, RUN, WAIT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mode_q, mode_d;
    logic [2:0]    arg1_q, arg1_d;
    logic [4:0]    arg2_q, arg2_d;
    logic [1:0]    code_q, code_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          rd_en_q, start_q, busy_q, err_q, err_d;
    logic          bad_op, gate_ok;
    logic [AW:0]   dp, rf, sf, a2, a2p1;

    // One extra bit on every operand so arg2+1 cannot wrap against a full-scale count
    assign dp     = {1'b0, data_pop};
    assign rf     = {1'b0, result_free_space};
    assign sf     = {1'b0, status_free_space};
    assign a2     = (AW+1)'(arg2_q);
    assign a2p1   = a2 + (AW+1)'(1);
    assign bad_op = mode_q > 8'd3;

    // Resource gate for the latched opcode: STP=0, EVP=1, EVB=2, RST=3 (RST never waits)
    always_comb begin
        gate_ok = (mode_q == 8'd0) ? (dp >= a2p1 && rf != '0 && sf != '0) :
                  (mode_q == 8'd1) ? (dp != '0 && rf >= a2 && sf >= a2) :
                  (mode_q == 8'd2) ? (dp >= a2 && rf >= a2 && sf >= a2) : 1'b1;
    end

    // Next-state, decode latch, watchdog and fault/count bookkeeping
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        arg1_d  = arg1_q;
        arg2_d  = arg2_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        wdog_d  = wdog_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE:  state_d = (command_pop != '0) ? FETCH : IDLE;
            FETCH: state_d = LATCH;
            LATCH: begin
                mode_d  = cmd_data[15:8];
                arg1_d  = cmd_data[7:5];
                arg2_d  = cmd_data[4:0];
                state_d = CHECK;
            end
            CHECK: begin
                if (bad_op) begin
                    err_d   = 1'b1;
                    code_d  = 2'b01;
                    state_d = IDLE;
                end else if (gate_ok) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = IDLE;
                end else if (wdog_q == WDOG_LAST) begin
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and all outputs registered; strobes are derived from the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            arg1_q  <= '0;
            arg2_q  <= '0;
            code_q  <= '0;
            cnt_q   <= '0;
            wdog_q  <= '0;
            rd_en_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            arg1_q  <= arg1_d;
            arg2_q  <= arg2_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
            rd_en_q <= state_d == FETCH;
            start_q <= state_d == RUN;
            busy_q  <= state_d != IDLE;
            err_q   <= err_d;
        end
    end

    assign cmd_rd_en    = rd_en_q;
    assign core_start   = start_q;
    assign core_mode    = mode_q;
    assign core_arg1    = arg1_q;
    assign core_arg2    = arg2_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign err_code     = code_q;
    assign invoke_count = cnt_q;
endmodule

// File: doc/pea_invoke_ctrl.md
Name: pea_invoke_ctrl

Overview:
Command-level scheduler for the polynomial evaluation accelerator (PEA) core. It pops one instruction from the command FIFO and decodes opcode and arguments. It then gates on FIFO occupancy/free-space, issues a single start pulse to the PEA datapath and waits for its completion handshake. A cycle watchdog and an invalid-opcode check report faults.

Parameters:
word_size, 16, width of command FIFO words
buffer_size, 1024, FIFO depth; occupancy ports are log2(buffer_size) bits wide
timeout_cycles, 4096, max cycles in WAIT before a timeout fault

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
command_pop  input  log2(buffer_size)  words in command FIFO
data_pop  input  log2(buffer_size)  words in data FIFO
result_free_space  input  log2(buffer_size)  free slots in result FIFO
status_free_space  input  log2(buffer_size)  free slots in status FIFO
cmd_data  input  word_size  command FIFO read data, valid the cycle after cmd_rd_en
core_done  input  1  one-cycle completion pulse from PEA core
cmd_rd_en  output  1  command FIFO pop strobe
core_start  output  1  one-cycle invoke pulse to PEA core
core_mode  output  8  latched opcode: 0 STP, 1 EVP, 2 EVB, 3 RST
core_arg1  output  3  latched polynomial slot id
core_arg2  output  5  latched count argument
busy  output  1  high in every state except IDLE
err  output  1  one-cycle fault pulse
err_code  output  2  01 bad opcode, 10 timeout; holds until next fault
invoke_count  output  16  completed invocations, wraps at 65535->0

Behaviour:
- Command word: [15:8] opcode, [7:5] arg1, [4:0] arg2. Only the 16 LSBs are decoded. Upper bits are ignored when word_size > 16.
- Reset: state IDLE. All outputs 0, including core_mode, core_arg1, core_arg2, err_code and invoke_count. Reset mid-operation aborts to IDLE immediately. No pop or start is issued that cycle.
- All outputs are registered.
- FSM states: IDLE, FETCH, LATCH, CHECK, RUN, WAIT.
- IDLE: if command_pop >= 1, go to FETCH. Otherwise stay.
- FETCH: cmd_rd_en=1 for exactly this cycle. Go to LATCH.
- LATCH: capture cmd_data into core_mode, core_arg1 and core_arg2. Go to CHECK.
- CHECK with an opcode greater than 3: err=1 and err_code=01 for one cycle. Drop the command and return to IDLE.
- CHECK with a valid opcode: go to RUN when the gate condition below is true. Otherwise stay in CHECK indefinitely; there is no timeout in CHECK.
- Gate STP: data_pop >= arg2+1, result_free_space >= 1 and status_free_space >= 1.
- Gate EVP: data_pop >= 1, result_free_space >= arg2 and status_free_space >= arg2.
- Gate EVB: data_pop >= arg2, result_free_space >= arg2 and status_free_space >= arg2.
- Gate RST: always true.
- RUN: core_start=1 for one cycle. Clear the watchdog. Go to WAIT.
- WAIT on core_done: increment invoke_count and go to IDLE.
- WAIT timeout: the watchdog reaches timeout_cycles-1 without core_done. Assert err=1 and err_code=10 for one cycle and go to IDLE. invoke_count does not increment.
- If core_done and the timeout expiry occur in the same cycle, done wins and no fault is raised.
- core_done outside WAIT is ignored.
- Arithmetic: all gate comparisons are evaluated at log2(buffer_size)+1 bits, so arg2+1 never wraps. arg2=0 is legal: EVB/EVP gates on zero counts pass.
- Latency: command visible in IDLE at cycle 0 gives cmd_rd_en at cycle 1. With the gate already true, core_start follows at cycle 4.
- core_mode, core_arg1 and core_arg2 hold stable from LATCH through the next LATCH.
- Back-to-back commands: there is at least one IDLE cycle between a done and the next FETCH.

Test Plan:
1. Reset, then command_pop=1 with cmd_data=0x0205 (EVB, arg2=5), data_pop=5, result_free_space=5, status_free_space=5 -> cmd_rd_en at cycle 1, core_start at cycle 4 with core_mode=2 and core_arg2=5. core_done 3 cycles later -> invoke_count=1, busy drops.
2. STP with arg2=31 (cmd 0x001F) and data_pop=31 -> stays in CHECK and core_start stays 0. Raise data_pop to 32 -> core_start the following cycle.
3. cmd_data=0x0700 (invalid opcode 7) -> err pulse with err_code=01, no core_start, back to IDLE. invoke_count unchanged.
4. RST command (0x0300) with all FIFOs empty except the command -> core_start is issued. Withhold core_done for 4096 cycles -> err pulse with err_code=10.
5. core_done asserted on the exact timeout-expiry cycle -> no err, invoke_count increments.
6. Assert rst during WAIT -> all outputs 0 immediately. A later core_done is ignored and there is no pop until command_pop >= 1 in IDLE.
